// File: rtl/pdm_audio_tx.sv
// PCM-to-PDM audio transmitter: sample FIFO, bit-rate divider and first-order sigma-delta modulator.
// Optional macro PDM_TX_DITHER_EN adds LFSR dither to the modulator sum.
module pdm_audio_tx #(
    parameter int CLK_DIV    = 32,
    parameter int OSR        = 64,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [15:0]                   sample_in,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    output logic                          pdm_out,
    output logic                          aud_sd,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int OW = (OSR > 1) ? $clog2(OSR) : 1;

    localparam logic [AW:0]   LVL_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   LVL_HALF = (AW+1)'(FIFO_DEPTH / 2);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [OW-1:0] OSR_LAST = OW'(OSR - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREFILL,
        S_RUN
    } state_t;

    state_t        r_state;
    logic [15:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic [DW-1:0] r_div;
    logic [OW-1:0] r_osr;
    logic [15:0]   r_acc;
    logic [15:0]   r_cur;
    logic          r_pdm;
    logic          r_sd;
    logic          r_urun;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_tick;
    logic          w_osr_end;
    logic          w_prefill_done;
    logic [15:0]   w_u;
    logic [16:0]   w_sum;

    assign w_full         = (r_level == LVL_FULL);
    assign w_empty        = (r_level == '0);
    assign w_push         = sample_valid && !w_full;
    assign w_tick         = (r_state != S_IDLE) && (r_div == DIV_LAST);
    assign w_osr_end      = (r_osr == OSR_LAST);
    assign w_prefill_done = (r_level >= LVL_HALF);

    // A pop only happens on a live tick; a tick coinciding with enable low is dropped
    assign w_pop = enable && w_tick &&
                   (((r_state == S_PREFILL) && w_prefill_done) ||
                    ((r_state == S_RUN) && w_osr_end && !w_empty));

    // Offset-binary conversion; prefill plays midscale silence
    assign w_u = (r_state == S_RUN) ? {~r_cur[15], r_cur[14:0]} : 16'h8000;

`ifdef PDM_TX_DITHER_EN
    logic [15:0] r_lfsr;
    logic        w_fb;
    logic [18:0] w_raw;

    assign w_fb  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_raw = {3'b000, r_acc} + {3'b000, w_u}
                 + {15'd0, r_lfsr[3:0]} - 19'd8;
    // Clamp at zero when negative and at the 17-bit ceiling on overflow
    assign w_sum = w_raw[18] ? 17'd0 :
                   w_raw[17] ? 17'h1FFFF : w_raw[16:0];

    // Dither LFSR advances on every live bit tick
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= 16'hACE1;
        end else if (w_tick && enable) begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
        end
    end
`else
    assign w_sum = {1'b0, r_acc} + {1'b0, w_u};
`endif

    // Sample storage; contents are discarded logically by resetting the pointers
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= sample_in;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level <= r_level + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

    // Playback state machine, bit divider and modulator with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_osr   <= '0;
            r_acc   <= '0;
            r_cur   <= 16'h0000;
            r_pdm   <= 1'b0;
            r_sd    <= 1'b0;
            r_urun  <= 1'b0;
        end else begin
            r_urun <= 1'b0;
            if (!enable) begin
                r_state <= S_IDLE;
                r_div   <= '0;
                r_osr   <= '0;
                r_acc   <= '0;
                r_pdm   <= 1'b0;
                r_sd    <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        r_state <= S_PREFILL;
                        r_sd    <= 1'b1;
                        r_div   <= '0;
                    end
                    S_PREFILL, S_RUN: begin
                        r_div <= w_tick ? '0 : r_div + 1'b1;
                        if (w_tick) begin
                            r_acc <= w_sum[15:0];
                            r_pdm <= w_sum[16];
                            if (r_state == S_PREFILL) begin
                                if (w_prefill_done) begin
                                    r_state <= S_RUN;
                                    r_cur   <= r_mem[r_rd_ptr];
                                    r_osr   <= '0;
                                end
                            end else if (w_osr_end) begin
                                r_osr <= '0;
                                if (w_empty) begin
                                    r_urun <= 1'b1;
                                end else begin
                                    r_cur <= r_mem[r_rd_ptr];
                                end
                            end else begin
                                r_osr <= r_osr + 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign sample_ready = !w_full;
    assign pdm_out      = r_pdm;
    assign aud_sd       = r_sd;
    assign underrun     = r_urun;
    assign fifo_level   = r_level;

endmodule

// File: tb/tb_pdm_audio_tx.sv
// Directed testbench for pdm_audio_tx.
// Checks reset, modulation patterns, back-pressure, underrun, reset and enable drop.
module tb_pdm_audio_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] sample_in = 16'h0000;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        pdm_out;
    logic        aud_sd;
    logic        underrun;
    logic [4:0]  fifo_level;

    int n_chk  = 0;
    int n_fail = 0;
    int ones;
    int ucnt;

    pdm_audio_tx dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .pdm_out      (pdm_out),
        .aud_sd       (aud_sd),
        .underrun     (underrun),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0;
        sample_valid = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    task automatic push(input logic [15:0] v);
        sample_in = v;
        sample_valid = 1'b1;
        step(1);
        sample_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_pdm", pdm_out, 0);
        chk("rst_sd", aud_sd, 0);
        chk("rst_urun", underrun, 0);
        chk("rst_lvl", fifo_level, 0);
        chk("rst_rdy", sample_ready, 1);

        // Midscale: prefill tick 0 then RUN ticks 1,0,1
        repeat (8) push(16'h0000);
        chk("mid_lvl8", fifo_level, 8);
        enable = 1'b1;
        step(1);
        chk("mid_sd", aud_sd, 1);
        step(31);
        chk("mid_pre_pdm", pdm_out, 0);
        chk("mid_pre_lvl", fifo_level, 8);
        step(1);
        chk("mid_pop_lvl", fifo_level, 7);
        chk("mid_b0", pdm_out, 0);
        step(32);
        chk("mid_b1", pdm_out, 1);
        step(32);
        chk("mid_b2", pdm_out, 0);
        step(32);
        chk("mid_b3", pdm_out, 1);

        // 16'h8000: all zeros for a sample period
        do_reset();
        repeat (8) push(16'h8000);
        enable = 1'b1;
        step(33);
        chk("neg_lvl", fifo_level, 7);
        ones = 0;
        repeat (64) begin
            step(32);
            ones += int'(pdm_out);
        end
        chk("neg_ones", ones, 0);

        // 16'h7FFF from acc=0: first bit 0, then 63 ones
        do_reset();
        repeat (7) push(16'h7FFF);
        enable = 1'b1;
        step(33);
        chk("pos_pre1_lvl", fifo_level, 7);
        chk("pos_pre1_pdm", pdm_out, 0);
        push(16'h7FFF);
        chk("pos_lvl8", fifo_level, 8);
        step(31);
        chk("pos_pre2_pdm", pdm_out, 1);
        chk("pos_pop_lvl", fifo_level, 7);
        step(32);
        chk("pos_first", pdm_out, 0);
        ones = 0;
        repeat (63) begin
            step(32);
            ones += int'(pdm_out);
        end
        chk("pos_ones", ones, 63);

        // Back-pressure: 17 back-to-back offers while disabled
        do_reset();
        sample_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            sample_in = 16'h1000 + 16'(i);
            step(1);
            if (i == 15) begin
                chk("bp_lvl16", fifo_level, 16);
                chk("bp_rdy0", sample_ready, 0);
            end
        end
        chk("bp_hold_lvl", fifo_level, 16);
        enable = 1'b1;
        step(32);
        chk("bp_prepop_lvl", fifo_level, 16);
        step(1);
        chk("bp_pop_lvl", fifo_level, 15);
        chk("bp_pop_rdy", sample_ready, 1);
        step(1);
        chk("bp_push17_lvl", fifo_level, 16);
        chk("bp_push17_rdy", sample_ready, 0);
        sample_valid = 1'b0;

        // Underrun after 8 samples of playback
        do_reset();
        repeat (8) push(16'h0000);
        enable = 1'b1;
        step(33);
        chk("ur_lvl7", fifo_level, 7);
        ucnt = 0;
        repeat (16383) begin
            step(1);
            ucnt += int'(underrun);
        end
        chk("ur_early", ucnt, 0);
        chk("ur_empty", fifo_level, 0);
        step(1);
        chk("ur_pulse", underrun, 1);
        chk("ur_pdm512", pdm_out, 0);
        step(1);
        chk("ur_pulse_end", underrun, 0);
        step(31);
        chk("ur_pdm513", pdm_out, 1);
        chk("ur_sd", aud_sd, 1);

        // Reset during RUN with level 5
        do_reset();
        repeat (8) push(16'h0000);
        enable = 1'b1;
        step(33);
        step(4096 + 10);
        chk("mr_lvl5", fifo_level, 5);
        chk("mr_sd1", aud_sd, 1);
        reset = 1'b1;
        step(1);
        chk("mr_pdm", pdm_out, 0);
        chk("mr_sd", aud_sd, 0);
        chk("mr_lvl", fifo_level, 0);
        chk("mr_rdy", sample_ready, 1);
        chk("mr_urun", underrun, 0);
        reset = 1'b0;
        enable = 1'b0;
        step(1);

        // Enable drop in RUN with level 6, then resume
        do_reset();
        repeat (8) push(16'h0000);
        enable = 1'b1;
        step(33);
        step(2080);
        chk("ed_pdm_run", pdm_out, 1);
        chk("ed_lvl6", fifo_level, 6);
        enable = 1'b0;
        step(1);
        chk("ed_sd0", aud_sd, 0);
        chk("ed_pdm0", pdm_out, 0);
        chk("ed_lvl_keep", fifo_level, 6);
        step(20);
        chk("ed_lvl_keep2", fifo_level, 6);
        enable = 1'b1;
        step(33);
        chk("re_sd", aud_sd, 1);
        chk("re_t1_pdm", pdm_out, 0);
        chk("re_t1_lvl", fifo_level, 6);
        step(32);
        chk("re_t2_pdm", pdm_out, 1);
        chk("re_t2_lvl", fifo_level, 6);
        push(16'h0000);
        push(16'h0000);
        chk("re_lvl8", fifo_level, 8);
        step(29);
        chk("re_prepop", fifo_level, 8);
        step(1);
        chk("re_run_lvl", fifo_level, 7);
        chk("re_t3_pdm", pdm_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
